// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder: word width, request FSM
// encoding and the RAM index-width helper.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-index width for a RAM of 'depth' words (depth is a power of two >= 2).
    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Single-port synchronous word RAM. One-cycle read; dout only changes on a
// read access, so it keeps its value across writes and idle cycles.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              cclk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge cclk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: word RAM behind a
// req/ready FSM with LATENCY wait states. Optional macro: MIPS_MEM_ALIGN_CHECK_EN.
//
// Handshake: req is sampled only while idle; the accepting edge is E0 and
// ready pulses for one cycle after edge E0+LATENCY, with rdata/err valid in
// that cycle. busy is high from E0 until ready; req seen while busy is dropped.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int               IDX_W  = idx_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_we;
    logic [IDX_W-1:0]  cap_idx;
    logic [WORD_W-1:0] cap_wdata;
    logic              cap_mis;
    logic              req_mis;

    logic              ram_en;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [WORD_W-1:0] ram_din;
    logic [WORD_W-1:0] ram_dout;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    logic unused_addr;
    assign req_mis     = (addr[1:0] != 2'b00);
    assign unused_addr = ^addr[WORD_W-1:IDX_W+2];
`else
    logic unused_addr;
    assign req_mis     = 1'b0;
    assign unused_addr = ^{addr[WORD_W-1:IDX_W+2], addr[1:0]};
`endif

    // RAM access happens on the edge that enters RESP. With LATENCY==1 that
    // is the accepting edge itself, so the live request inputs feed the RAM.
    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_idx = cap_idx;
        ram_din = cap_wdata;
        if (state == IDLE && req && LATENCY == 1) begin
            ram_en  = 1'b1;
            ram_we  = we && !req_mis;
            ram_idx = addr[IDX_W+1:2];
            ram_din = wdata;
        end else if (state == WAIT && cnt == CNT_W'(1)) begin
            ram_en  = 1'b1;
            ram_we  = cap_we && !cap_mis;
        end
        // A write whose commit edge is also a reset edge is dropped.
        ram_we = ram_we && rstb;
    end

    mips_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .cclk (cclk),
        .en   (ram_en),
        .we   (ram_we),
        .idx  (ram_idx),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_mis   <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_idx   <= addr[IDX_W+1:2];
                        cap_wdata <= wdata;
                        cap_mis   <= req_mis;
                        cnt       <= LAT_M1;
                        busy      <= 1'b1;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    err   <= cap_mis;
                    // ram_dout was loaded on the edge that entered RESP.
                    if (cap_mis) begin
                        rdata <= '0;
                    end else if (!cap_we) begin
                        rdata <= ram_dout;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
